// File: rtl/shake_ctrl_if.sv
// ---------------------------------------------------------------------------
// shake_ctrl_if
// Bundles every handshake and status signal between the SHAKE sequencing
// controller and its surroundings (host, padder, Keccak core, consumer).
//
// master : the controller side (drives pulses, out_valid/out_idx, status)
// slave  : the environment side (drives start/sq_blocks, pad_*, perm_done,
//          out_ready)
//
// Signals
//   start, sq_blocks          host request and squeeze block count
//   pad_start, pad_next_block pulses to the padder
//   pad_done, pad_last        padder block-complete and final-block flags
//   state_clear, absorb_en    pulses to the Keccak state register
//   perm_start, perm_done     permutation launch / completion
//   out_valid, out_ready      squeeze-block handshake
//   out_idx                   index of the offered squeeze block
//   busy, done, debug_state   status
// ---------------------------------------------------------------------------
interface shake_ctrl_if #(
    parameter int MAX_SQ_BITS = 8
);
    logic                   start;
    logic [MAX_SQ_BITS-1:0] sq_blocks;
    logic                   pad_start;
    logic                   pad_next_block;
    logic                   pad_done;
    logic                   pad_last;
    logic                   state_clear;
    logic                   absorb_en;
    logic                   perm_start;
    logic                   perm_done;
    logic                   out_valid;
    logic                   out_ready;
    logic [MAX_SQ_BITS-1:0] out_idx;
    logic                   busy;
    logic                   done;
    logic [2:0]             debug_state;

    modport master (
        input  start, sq_blocks, pad_done, pad_last, perm_done, out_ready,
        output pad_start, pad_next_block, state_clear, absorb_en, perm_start,
               out_valid, out_idx, busy, done, debug_state
    );

    modport slave (
        output start, sq_blocks, pad_done, pad_last, perm_done, out_ready,
        input  pad_start, pad_next_block, state_clear, absorb_en, perm_start,
               out_valid, out_idx, busy, done, debug_state
    );
endinterface

// File: rtl/shake_ctrl.sv
// ---------------------------------------------------------------------------
// shake_ctrl
// Sequencing controller for a SHAKE-style sponge: clears the Keccak state,
// absorbs padded message blocks one permutation at a time until the padder
// flags the final block, then squeezes a host-requested number of 1088-bit
// output blocks with a valid/ready handshake.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous active-high reset (priority over all inputs)
//   bus    shake_ctrl_if.master carrying all handshake/status signals
//
// All pulse outputs (pad_start, pad_next_block, state_clear, absorb_en,
// perm_start, done) come straight from flops, so each is high for exactly
// the cycle after the decision that produced it.
// ---------------------------------------------------------------------------
module shake_ctrl #(
    parameter int MAX_SQ_BITS = 8
) (
    input  logic          clk,
    input  logic          reset,
    shake_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PAD_WAIT = 3'd1,
        ABSORB   = 3'd2,
        PERM     = 3'd3,
        SQ_OUT   = 3'd4,
        SQ_PERM  = 3'd5,
        FINISH   = 3'd6
    } state_t;

    localparam logic [MAX_SQ_BITS-1:0] CNT_ONE = MAX_SQ_BITS'(1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [MAX_SQ_BITS-1:0] r_count;
    logic [MAX_SQ_BITS-1:0] w_count_next;
    logic [MAX_SQ_BITS-1:0] r_out_idx;
    logic [MAX_SQ_BITS-1:0] w_out_idx_next;
    logic [MAX_SQ_BITS-1:0] w_idx_inc;
    logic                   r_last;
    logic                   w_last_next;

    logic r_pad_start,      w_pad_start_next;
    logic r_pad_next_block, w_pad_next_block_next;
    logic r_state_clear,    w_state_clear_next;
    logic r_absorb_en,      w_absorb_en_next;
    logic r_perm_start,     w_perm_start_next;
    logic r_done,           w_done_next;

    // Same width as the counter: with count <= 2^N-1 the increment reaches
    // the count before it could ever wrap.
    assign w_idx_inc = r_out_idx + CNT_ONE;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_count          <= '0;
            r_out_idx        <= '0;
            r_last           <= 1'b0;
            r_pad_start      <= 1'b0;
            r_pad_next_block <= 1'b0;
            r_state_clear    <= 1'b0;
            r_absorb_en      <= 1'b0;
            r_perm_start     <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_count          <= w_count_next;
            r_out_idx        <= w_out_idx_next;
            r_last           <= w_last_next;
            r_pad_start      <= w_pad_start_next;
            r_pad_next_block <= w_pad_next_block_next;
            r_state_clear    <= w_state_clear_next;
            r_absorb_en      <= w_absorb_en_next;
            r_perm_start     <= w_perm_start_next;
            r_done           <= w_done_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and pulse-request logic. Each input is only looked at in
    // the state that expects it, which is what makes stray pad_done,
    // perm_done, start and out_ready harmless everywhere else.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next          = r_state;
        w_count_next          = r_count;
        w_out_idx_next        = r_out_idx;
        w_last_next           = r_last;
        w_pad_start_next      = 1'b0;
        w_pad_next_block_next = 1'b0;
        w_state_clear_next    = 1'b0;
        w_absorb_en_next      = 1'b0;
        w_perm_start_next     = 1'b0;
        w_done_next           = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    // A zero request still produces one block.
                    w_count_next       = (bus.sq_blocks == '0) ? CNT_ONE
                                                               : bus.sq_blocks;
                    w_out_idx_next     = '0;
                    w_last_next        = 1'b0;
                    w_state_clear_next = 1'b1;
                    w_pad_start_next   = 1'b1;
                    w_state_next       = PAD_WAIT;
                end
            end

            PAD_WAIT: begin
                if (bus.pad_done) begin
                    w_last_next      = bus.pad_last;
                    w_absorb_en_next = 1'b1;
                    w_state_next     = ABSORB;
                end
            end

            ABSORB: begin
                w_perm_start_next = 1'b1;
                w_state_next      = PERM;
            end

            PERM: begin
                if (bus.perm_done) begin
                    if (r_last) begin
                        w_state_next = SQ_OUT;
                    end else begin
                        w_pad_next_block_next = 1'b1;
                        w_state_next          = PAD_WAIT;
                    end
                end
            end

            SQ_OUT: begin
                // out_valid is implied by the state, so out_ready alone is
                // the acceptance condition here.
                if (bus.out_ready) begin
                    if (w_idx_inc == r_count) begin
                        w_done_next  = 1'b1;
                        w_state_next = FINISH;
                    end else begin
                        w_out_idx_next    = w_idx_inc;
                        w_perm_start_next = 1'b1;
                        w_state_next      = SQ_PERM;
                    end
                end
            end

            SQ_PERM: begin
                if (bus.perm_done) begin
                    w_state_next = SQ_OUT;
                end
            end

            FINISH: begin
                // done is already high this cycle from the registered pulse.
                w_state_next = IDLE;
            end

            default: begin
                // Encoding 7 is unreachable; recover quietly.
                w_state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.pad_start      = r_pad_start;
    assign bus.pad_next_block = r_pad_next_block;
    assign bus.state_clear    = r_state_clear;
    assign bus.absorb_en      = r_absorb_en;
    assign bus.perm_start     = r_perm_start;
    assign bus.done           = r_done;
    assign bus.out_valid      = (r_state == SQ_OUT);
    assign bus.out_idx        = r_out_idx;
    assign bus.busy           = (r_state != IDLE);
    assign bus.debug_state    = r_state;

endmodule

// File: tb/tb_shake_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shake_ctrl
// Directed bench for shake_ctrl. Inputs are driven and outputs sampled on
// the falling edge; a monitor counts each pulse output and flags any pulse
// high on two consecutive cycles.
// ---------------------------------------------------------------------------
module tb_shake_ctrl;

    localparam int W = 8;

    // debug_state encodings
    localparam logic [2:0] S_IDLE = 3'd0, S_PADW = 3'd1, S_ABS = 3'd2,
                           S_PERM = 3'd3, S_SQO = 3'd4, S_SQP = 3'd5,
                           S_FIN = 3'd6;

    // Packed view of the single-bit outputs:
    // {pad_start, pad_next_block, state_clear, absorb_en, perm_start,
    //  out_valid, busy, done}
    localparam logic [7:0] O_BUSY      = 8'b0000_0010;
    localparam logic [7:0] O_VALIDBUSY = 8'b0000_0110;
    localparam logic [7:0] O_DONEBUSY  = 8'b0000_0011;
    localparam logic [7:0] O_ABSBUSY   = 8'b0001_0010;
    localparam logic [7:0] O_PERMBUSY  = 8'b0000_1010;
    localparam logic [7:0] O_STARTBUSY = 8'b1010_0010;
    localparam logic [7:0] O_NEXTBUSY  = 8'b0100_0010;

    logic clk = 1'b0;
    logic reset;

    shake_ctrl_if #(.MAX_SQ_BITS(W)) bus();

    shake_ctrl #(.MAX_SQ_BITS(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    logic [7:0] outs;
    assign outs = {bus.pad_start, bus.pad_next_block, bus.state_clear,
                   bus.absorb_en, bus.perm_start, bus.out_valid, bus.busy,
                   bus.done};

    // ---------------- pulse monitor ----------------
    int n_pad_start = 0, n_pad_next = 0, n_clear = 0, n_absorb = 0;
    int n_perm = 0, n_done = 0, n_consec = 0;
    logic [5:0] prev_pulses = '0;

    always @(negedge clk) begin
        logic [5:0] p;
        p = {bus.pad_start, bus.pad_next_block, bus.state_clear,
             bus.absorb_en, bus.perm_start, bus.done};
        if (bus.pad_start)      n_pad_start++;
        if (bus.pad_next_block) n_pad_next++;
        if (bus.state_clear)    n_clear++;
        if (bus.absorb_en)      n_absorb++;
        if (bus.perm_start)     n_perm++;
        if (bus.done)           n_done++;
        if ((p & prev_pulses) != 6'd0) n_consec++;
        prev_pulses = p;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        for (int k = 0; k < budget && bus.debug_state != s; k++) tick();
        chk("wait_state", 32'(bus.debug_state), 32'(s));
    endtask

    // Start a hash; afterwards sq_blocks is scrambled to prove it was latched.
    task automatic start_op(input logic [W-1:0] n);
        bus.start = 1'b1;
        bus.sq_blocks = n;
        tick();
        bus.start = 1'b0;
        bus.sq_blocks = 8'd9;
    endtask

    // Absorb nblk blocks, pad_last on the final one.
    task automatic feed(input int nblk);
        for (int b = 0; b < nblk; b++) begin
            wait_state(S_PADW, 50);
            repeat (3) tick();
            bus.pad_done = 1'b1;
            bus.pad_last = (b == nblk - 1);
            tick();
            bus.pad_done = 1'b0;
            bus.pad_last = 1'b0;
            chk("feed_absorb", 32'(outs), 32'(O_ABSBUSY));
            tick();
            chk("feed_perm", 32'(outs), 32'(O_PERMBUSY));
            repeat (4) tick();
            bus.perm_done = 1'b1;
            tick();
            bus.perm_done = 1'b0;
            if (b < nblk - 1) chk("feed_next", 32'(outs), 32'(O_NEXTBUSY));
            else              chk("feed_sqo", 32'(bus.debug_state), 32'(S_SQO));
        end
    endtask

    // Squeeze n blocks; hold=1 keeps out_ready high throughout.
    task automatic squeeze(input int n, input bit hold);
        bus.out_ready = hold;
        for (int i = 0; i < n; i++) begin
            wait_state(S_SQO, 50);
            chk("sq_idx", 32'(bus.out_idx), 32'(i));
            chk("sq_valid", 32'(outs), 32'(O_VALIDBUSY));
            if (!hold) bus.out_ready = 1'b1;
            tick();
            if (!hold) bus.out_ready = 1'b0;
            if (i < n - 1) begin
                chk("sq_perm", 32'(outs), 32'(O_PERMBUSY));
                bus.perm_done = 1'b1;
                tick();
                bus.perm_done = 1'b0;
            end else begin
                chk("sq_fin_state", 32'(bus.debug_state), 32'(S_FIN));
                chk("sq_done", 32'(outs), 32'(O_DONEBUSY));
                tick();
                chk("sq_idle", 32'(bus.debug_state), 32'(S_IDLE));
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset(input bit with_start);
        reset = 1'b1;
        bus.start = with_start;
        tick();
        reset = 1'b0;
        bus.start = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int s_perm, s_absorb, s_next, s_done, s_clear, s_pstart;

    task automatic snap();
        s_perm = n_perm; s_absorb = n_absorb; s_next = n_pad_next;
        s_done = n_done; s_clear = n_clear; s_pstart = n_pad_start;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.sq_blocks = '0; bus.pad_done = 1'b0;
        bus.pad_last = 1'b0; bus.perm_done = 1'b0; bus.out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_state", 32'(bus.debug_state), 32'(S_IDLE));
        chk("rst_outs", 32'(outs), 32'd0);
        chk("rst_idx", 32'(bus.out_idx), 32'd0);

        // 1: single block, one squeeze block, spec timing
        snap();
        start_op(8'd1);
        chk("t1_pad_wait", 32'(bus.debug_state), 32'(S_PADW));
        chk("t1_start_pulses", 32'(outs), 32'(O_STARTBUSY));
        tick();
        chk("t1_pulse_end", 32'(outs), 32'(O_BUSY));
        repeat (18) tick();
        bus.pad_done = 1'b1; bus.pad_last = 1'b1;
        tick();
        bus.pad_done = 1'b0; bus.pad_last = 1'b0;
        chk("t1_absorb", 32'(outs), 32'(O_ABSBUSY));
        tick();
        chk("t1_perm", 32'(outs), 32'(O_PERMBUSY));
        repeat (23) tick();
        bus.perm_done = 1'b1;
        tick();
        bus.perm_done = 1'b0;
        chk("t1_sq_out", 32'(outs), 32'(O_VALIDBUSY));
        chk("t1_idx", 32'(bus.out_idx), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t1_done", 32'(outs), 32'(O_DONEBUSY));
        tick();
        chk("t1_idle", 32'(outs), 32'd0);
        chk("t1_n_clear", 32'(n_clear - s_clear), 32'd1);
        chk("t1_n_pstart", 32'(n_pad_start - s_pstart), 32'd1);
        chk("t1_n_absorb", 32'(n_absorb - s_absorb), 32'd1);
        chk("t1_n_perm", 32'(n_perm - s_perm), 32'd1);
        chk("t1_n_done", 32'(n_done - s_done), 32'd1);
        $display("op 1: single block, 1 squeeze block");

        // 2: three message blocks
        snap();
        start_op(8'd1);
        feed(3);
        chk("t2_n_next", 32'(n_pad_next - s_next), 32'd2);
        chk("t2_n_absorb", 32'(n_absorb - s_absorb), 32'd3);
        chk("t2_n_perm", 32'(n_perm - s_perm), 32'd3);
        squeeze(1, 1'b0);
        $display("op 2: three message blocks");

        // 3: four squeeze blocks, out_ready held high
        snap();
        start_op(8'd4);
        feed(1);
        squeeze(4, 1'b1);
        chk("t3_n_perm", 32'(n_perm - s_perm), 32'd4);
        chk("t3_n_done", 32'(n_done - s_done), 32'd1);
        chk("t3_idx_kept", 32'(bus.out_idx), 32'd3);
        $display("op 3: four squeeze blocks, ready held");

        // 4: sq_blocks = 0 behaves as 1
        snap();
        start_op(8'd0);
        feed(1);
        squeeze(1, 1'b0);
        chk("t4_n_perm", 32'(n_perm - s_perm), 32'd1);
        $display("op 4: zero squeeze request");

        // 5: back-pressure for 10 cycles
        start_op(8'd2);
        feed(1);
        snap();
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t5_valid", 32'(outs), 32'(O_VALIDBUSY));
            chk("t5_idx", 32'(bus.out_idx), 32'd0);
        end
        chk("t5_no_perm", 32'(n_perm - s_perm), 32'd0);
        squeeze(2, 1'b0);
        $display("op 5: back-pressure");

        // 6: spurious inputs in the wrong states
        bus.pad_done = 1'b1; bus.pad_last = 1'b1; bus.perm_done = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.pad_done = 1'b0; bus.pad_last = 1'b0; bus.perm_done = 1'b0;
        bus.out_ready = 1'b0;
        chk("t6_idle_state", 32'(bus.debug_state), 32'(S_IDLE));
        tick();
        chk("t6_idle_outs", 32'(outs), 32'd0);
        start_op(8'd2);
        tick();
        bus.perm_done = 1'b1; bus.start = 1'b1;
        tick();
        bus.perm_done = 1'b0; bus.start = 1'b0;
        chk("t6_padw_state", 32'(bus.debug_state), 32'(S_PADW));
        chk("t6_padw_outs", 32'(outs), 32'(O_BUSY));
        bus.pad_done = 1'b1; bus.pad_last = 1'b1;
        tick();
        bus.pad_done = 1'b0; bus.pad_last = 1'b0;
        tick();
        tick();
        bus.pad_done = 1'b1; bus.start = 1'b1;
        tick();
        bus.pad_done = 1'b0; bus.start = 1'b0;
        chk("t6_perm_state", 32'(bus.debug_state), 32'(S_PERM));
        chk("t6_perm_outs", 32'(outs), 32'(O_BUSY));
        bus.pad_done = 1'b1; bus.perm_done = 1'b1;
        tick();
        bus.pad_done = 1'b0; bus.perm_done = 1'b0;
        chk("t6_both_done", 32'(bus.debug_state), 32'(S_SQO));
        bus.pad_done = 1'b1; bus.perm_done = 1'b1; bus.start = 1'b1;
        tick();
        bus.pad_done = 1'b0; bus.perm_done = 1'b0; bus.start = 1'b0;
        chk("t6_sqo_state", 32'(bus.debug_state), 32'(S_SQO));
        chk("t6_sqo_outs", 32'(outs), 32'(O_VALIDBUSY));
        squeeze(2, 1'b0);
        $display("op 6: spurious inputs");

        // 7a: reset during PERM, then stale done pulses, then fresh op
        start_op(8'd1);
        bus.pad_done = 1'b1; bus.pad_last = 1'b1;
        tick();
        bus.pad_done = 1'b0; bus.pad_last = 1'b0;
        tick();
        chk("t7_in_perm", 32'(bus.debug_state), 32'(S_PERM));
        do_reset(1'b0);
        chk("t7_rst_state", 32'(bus.debug_state), 32'(S_IDLE));
        chk("t7_rst_outs", 32'(outs), 32'd0);
        bus.perm_done = 1'b1; bus.pad_done = 1'b1;
        tick();
        bus.perm_done = 1'b0; bus.pad_done = 1'b0;
        chk("t7_stale", 32'(bus.debug_state), 32'(S_IDLE));
        start_op(8'd1);
        feed(1);
        squeeze(1, 1'b0);

        // 7b: reset (with start) during SQ_OUT at idx 1
        start_op(8'd3);
        feed(1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.perm_done = 1'b1;
        tick();
        bus.perm_done = 1'b0;
        chk("t7_sq_idx1", 32'(bus.out_idx), 32'd1);
        do_reset(1'b1);
        chk("t7_rst2_state", 32'(bus.debug_state), 32'(S_IDLE));
        chk("t7_rst2_outs", 32'(outs), 32'd0);
        chk("t7_rst2_idx", 32'(bus.out_idx), 32'd0);
        start_op(8'd2);
        feed(1);
        squeeze(2, 1'b0);
        $display("op 7: reset in PERM and SQ_OUT");

        // 8: maximum count, no wrap before FINISH
        snap();
        start_op(8'd255);
        feed(1);
        squeeze(255, 1'b1);
        chk("t8_n_perm", 32'(n_perm - s_perm), 32'd255);
        chk("t8_idx_kept", 32'(bus.out_idx), 32'd254);
        $display("op 8: 255 squeeze blocks");

        tick();
        chk("no_consec_pulses", 32'(n_consec), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
